// File: rtl/conv_alu_if.sv
// Operand, opcode and result/status bundle for conv_alu.
// Handshake: valid_in qualifies ALUControl only for the sequential ops (load
// and convolution start); a sequential op is taken on a rising clk edge when
// valid_in=1 and busy=0, and is dropped without effect otherwise. busy is the
// ready signal inverted. Combinational ops ignore valid_in.
interface conv_alu_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  logic [2:0]        ALUControl;
  logic              valid_in;
  logic [DATA_W-1:0] Result;
  logic              Carry;
  logic              OverFlow;
  logic              Zero;
  logic              Negative;
  logic              busy;
  logic              done;
  logic              err;
  logic [1:0]        dbg_state;

  modport master (
    output A, B, ALUControl, valid_in,
    input  Result, Carry, OverFlow, Zero, Negative, busy, done, err, dbg_state
  );

  modport slave (
    input  A, B, ALUControl, valid_in,
    output Result, Carry, OverFlow, Zero, Negative, busy, done, err, dbg_state
  );
endinterface

// File: rtl/conv_alu.sv
// conv_alu: 32-bit style ALU with add/sub/and/or/ReLU plus a K*K window
// buffer and a sequential signed MAC engine that computes one dot product
// of activations and weights per convolution request.
// ACC_W must satisfy 2*ELEM_W+4 <= ACC_W <= DATA_W; K must be 2..4.
module conv_alu #(
  parameter int DATA_W = 32,
  parameter int ELEM_W = 8,
  parameter int K      = 3,
  parameter int ACC_W  = 20
) (
  input  logic       clk,
  input  logic       rst,
  conv_alu_if.slave  bus
);

  localparam int NSLOT  = K * K;
  localparam int IDX_W  = $clog2(NSLOT);
  localparam int FILL_W = $clog2(NSLOT + 1);
  localparam int LANES  = DATA_W / ELEM_W;

  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NSLOT - 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(NSLOT);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_LOAD = 3'b100;
  localparam logic [2:0] OP_RELU = 3'b101;
  localparam logic [2:0] OP_CONV = 3'b110;
  localparam logic [2:0] OP_READ = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic signed [ELEM_W-1:0] r_act [NSLOT];
  logic signed [ELEM_W-1:0] r_wt  [NSLOT];
  logic [IDX_W-1:0]         r_wr_ptr;
  logic [IDX_W-1:0]         r_idx;
  logic [FILL_W-1:0]        r_fill;
  logic signed [ACC_W-1:0]  r_acc;
  logic [DATA_W-1:0]        r_conv_res;
  logic                     r_err;

  logic                     w_busy;
  logic                     w_done;
  logic                     w_load_en;
  logic                     w_start;
  logic                     w_err_set;
  logic                     w_full;
  logic signed [2*ELEM_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_prod_ext;

  logic                     w_is_sub;
  logic [DATA_W-1:0]        w_b_op;
  logic [DATA_W:0]          w_sum;
  logic                     w_add_ovf;
  logic [DATA_W-1:0]        w_relu;
  logic [DATA_W-1:0]        w_result;
  logic                     w_carry;
  logic                     w_ovf;

  assign w_full     = (r_fill == FILL_FULL);
  assign w_prod     = r_act[r_idx] * r_wt[r_idx];
  assign w_prod_ext = ACC_W'(w_prod);

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next state and control strobes; sequential ops are only taken in IDLE.
  always_comb begin
    w_next    = r_state;
    w_busy    = 1'b0;
    w_done    = 1'b0;
    w_load_en = 1'b0;
    w_start   = 1'b0;
    w_err_set = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.valid_in && (bus.ALUControl == OP_LOAD)) begin
          w_load_en = 1'b1;
        end
        if (bus.valid_in && (bus.ALUControl == OP_CONV)) begin
          if (w_full) begin
            w_start = 1'b1;
            w_next  = S_MAC;
          end else begin
            w_err_set = 1'b1;
          end
        end
      end
      S_MAC: begin
        w_busy = 1'b1;
        if (r_idx == IDX_LAST) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        w_busy = 1'b1;
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Window buffer, pointers, accumulator, committed result and sticky error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NSLOT; i++) begin
        r_act[i] <= '0;
        r_wt[i]  <= '0;
      end
      r_wr_ptr   <= '0;
      r_idx      <= '0;
      r_fill     <= '0;
      r_acc      <= '0;
      r_conv_res <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_load_en) begin
        r_act[r_wr_ptr] <= bus.B[2*ELEM_W-1:ELEM_W];
        r_wt[r_wr_ptr]  <= bus.B[ELEM_W-1:0];
        // Pointer runs modulo K*K so a full window overwrites its oldest slot.
        r_wr_ptr <= (r_wr_ptr == IDX_LAST) ? '0 : r_wr_ptr + IDX_W'(1);
        if (!w_full) begin
          r_fill <= r_fill + FILL_W'(1);
        end
      end
      if (w_start) begin
        r_acc <= '0;
        r_idx <= '0;
      end
      if (r_state == S_MAC) begin
        r_acc <= r_acc + w_prod_ext;
        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
      end
      if (r_state == S_DONE) begin
        r_conv_res <= DATA_W'(r_acc);
        r_fill     <= '0;
        r_wr_ptr   <= '0;
      end
      if (w_err_set) begin
        r_err <= 1'b1;
      end
    end
  end

  // Shared adder: subtraction is A + ~B + 1, so one overflow rule covers both.
  always_comb begin
    w_is_sub  = (bus.ALUControl == OP_SUB);
    w_b_op    = w_is_sub ? ~bus.B : bus.B;
    w_sum     = {1'b0, bus.A} + {1'b0, w_b_op} + {{DATA_W{1'b0}}, w_is_sub};
    w_add_ovf = (bus.A[DATA_W-1] == w_b_op[DATA_W-1]) &&
                (w_sum[DATA_W-1] != bus.A[DATA_W-1]);
  end

  // Lane-wise ReLU; bits above the last whole lane pass through untouched.
  always_comb begin
    w_relu = bus.A;
    for (int l = 0; l < LANES; l++) begin
      if (bus.A[l*ELEM_W + ELEM_W - 1]) begin
        w_relu[l*ELEM_W +: ELEM_W] = '0;
      end
    end
  end

  // Result mux; Carry/OverFlow are meaningful only for add/sub.
  always_comb begin
    w_result = '0;
    w_carry  = 1'b0;
    w_ovf    = 1'b0;
    case (bus.ALUControl)
      OP_ADD, OP_SUB: begin
        w_result = w_sum[DATA_W-1:0];
        w_carry  = w_sum[DATA_W];
        w_ovf    = w_add_ovf;
      end
      OP_AND:  w_result = bus.A & bus.B;
      OP_OR:   w_result = bus.A | bus.B;
      OP_LOAD: w_result = bus.B;
      OP_RELU: w_result = w_relu;
      OP_CONV: w_result = '0;
      OP_READ: w_result = r_conv_res;
      default: w_result = '0;
    endcase
  end

  assign bus.Result    = w_result;
  assign bus.Carry     = w_carry;
  assign bus.OverFlow  = w_ovf;
  assign bus.Zero      = (w_result == '0);
  assign bus.Negative  = w_result[DATA_W-1];
  assign bus.busy      = w_busy;
  assign bus.done      = w_done;
  assign bus.err       = r_err;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_conv_alu.sv
// Directed-plus-random bench for conv_alu with a window/dot-product model.
module tb_conv_alu;

  localparam int NSLOT = 9;
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_LOAD = 3'b100;
  localparam logic [2:0] OP_RELU = 3'b101;
  localparam logic [2:0] OP_CONV = 3'b110;
  localparam logic [2:0] OP_READ = 3'b111;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  conv_alu_if #(.DATA_W(32)) bus ();

  conv_alu #(.DATA_W(32), .ELEM_W(8), .K(3), .ACC_W(20)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // reference model state
  logic [15:0] win[$];
  logic [31:0] exp_conv;
  logic        exp_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_dot();
    int s;
    byte a;
    byte w;
    s = 0;
    foreach (win[i]) begin
      a = win[i][15:8];
      w = win[i][7:0];
      s = s + a * w;
    end
    return 32'(s);
  endfunction

  // combinational ALU op checked against plain arithmetic
  task automatic alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] u;
    longint      s;
    logic [31:0] r;
    logic        c;
    logic        v;
    byte         lane;
    @(negedge clk);
    bus.valid_in = 1'b0;
    bus.ALUControl = op;
    bus.A = a;
    bus.B = b;
    #1;
    r = 32'h0; c = 1'b0; v = 1'b0;
    case (op)
      OP_ADD: begin
        u = {32'h0, a} + {32'h0, b};
        r = u[31:0];
        c = (u > 64'hFFFF_FFFF);
        s = longint'($signed(a)) + longint'($signed(b));
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      OP_SUB: begin
        r = a - b;
        c = (a >= b);
        s = longint'($signed(a)) - longint'($signed(b));
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_LOAD: r = b;
      OP_RELU: begin
        r = a;
        for (int i = 0; i < 4; i++) begin
          lane = a[8*i +: 8];
          if (lane < 0) r[8*i +: 8] = 8'h00;
        end
      end
      OP_CONV: r = 32'h0;
      default: r = exp_conv;
    endcase
    check("alu_result", bus.Result, r);
    check("alu_carry", bus.Carry, c);
    check("alu_ovf", bus.OverFlow, v);
    check("alu_zero", bus.Zero, (r == 32'h0));
    check("alu_neg", bus.Negative, r[31]);
  endtask

  // driver: one load in IDLE
  task automatic do_load(input logic [7:0] a, input logic [7:0] w);
    logic [15:0] hi;
    logic [31:0] bv;
    hi = 16'($urandom);
    bv = {hi, a, w};
    @(negedge clk);
    bus.ALUControl = OP_LOAD;
    bus.valid_in = 1'b1;
    bus.B = bv;
    #1 check("load_result", bus.Result, bv);
    win.push_back({a, w});
    if (win.size() > NSLOT) void'(win.pop_front());
  endtask

  task automatic rand_loads(input int n);
    for (int i = 0; i < n; i++) do_load(8'($urandom), 8'($urandom));
  endtask

  // issue 110 and follow the engine; mode 1 = load during MAC, 2 = hold 110 during MAC
  task automatic run_conv(input int rst_at, input int mode, output int dc, output int nb);
    @(negedge clk);
    bus.ALUControl = OP_CONV;
    bus.valid_in = 1'b1;
    bus.A = $urandom;
    bus.B = $urandom;
    #1 check("conv_issue_result", bus.Result, 32'h0);
    dc = 0;
    nb = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      bus.ALUControl = OP_READ;
      bus.valid_in = 1'b0;
      if (mode == 1 && c == 1) begin
        bus.ALUControl = OP_LOAD;
        bus.valid_in = 1'b1;
        bus.B = 32'h0000_7F7F;
      end
      if (mode == 2 && c >= 2 && c <= 5) begin
        bus.ALUControl = OP_CONV;
        bus.valid_in = 1'b1;
      end
      if (c == rst_at) begin
        rst = 1'b0;
        #1;
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        #3 rst = 1'b1;
        break;
      end
      #1;
      if (bus.busy) nb++;
      if (bus.done) dc = c;
      if (!bus.busy) break;
    end
  endtask

  // full convolution on a full window, compared with the model dot product
  task automatic full_conv(input int mode);
    int dc;
    int nb;
    logic [31:0] e;
    e = model_dot();
    run_conv(0, mode, dc, nb);
    check("conv_done_cycle", 32'(dc), 32'(NSLOT + 1));
    check("conv_busy_cycles", 32'(nb), 32'(NSLOT + 1));
    check("conv_read", bus.Result, e);
    check("conv_zero", bus.Zero, (e == 32'h0));
    check("conv_neg", bus.Negative, e[31]);
    check("conv_err", bus.err, exp_err);
    exp_conv = e;
    win.delete();
  endtask

  initial begin
    int dc;
    int nb;
    int ndone;
    total = 0;
    bad = 0;
    exp_conv = 32'h0;
    exp_err = 1'b0;
    rst = 1'b0;
    bus.A = 32'h0;
    bus.B = 32'h0;
    bus.ALUControl = OP_READ;
    bus.valid_in = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy0", bus.busy, 1'b0);
    check("rst_done0", bus.done, 1'b0);
    check("rst_err0", bus.err, 1'b0);
    check("rst_read0", bus.Result, 32'h0);
    check("rst_zero0", bus.Zero, 1'b1);
    @(negedge clk);
    rst = 1'b1;

    // directed ALU corners
    alu(OP_ADD, 32'h7FFF_FFFF, 32'h1);
    check("add_ovf_result", bus.Result, 32'h8000_0000);
    check("add_ovf_flag", bus.OverFlow, 1'b1);
    check("add_ovf_carry", bus.Carry, 1'b0);
    alu(OP_SUB, 32'd5, 32'd5);
    check("sub_zero", bus.Zero, 1'b1);
    check("sub_carry", bus.Carry, 1'b1);
    alu(OP_RELU, 32'h807F_FF01, 32'h0);
    check("relu_vec", bus.Result, 32'h007F_0001);
    alu(OP_ADD, 32'hFFFF_FFFF, 32'h1);
    alu(OP_SUB, 32'h8000_0000, 32'h1);

    // random ALU traffic
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      a = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF : 32'($urandom);
      b = ($urandom_range(0, 3) == 0) ? a : 32'($urandom);
      alu(3'($urandom_range(0, 5)), a, b);
    end

    // nine (2,1) loads -> 18
    for (int i = 0; i < NSLOT; i++) do_load(8'd2, 8'd1);
    full_conv(0);
    check("conv_18", bus.Result, 32'd18);

    // nine (-3,4) loads -> -108
    for (int i = 0; i < NSLOT; i++) do_load(8'hFD, 8'd4);
    full_conv(0);
    check("conv_m108", bus.Result, 32'hFFFF_FF94);
    check("conv_m108_neg", bus.Negative, 1'b1);

    // partial window: rejected, err set next cycle, result unchanged
    for (int i = 0; i < 5; i++) do_load(8'($urandom_range(0, 100) - 50), 8'($urandom_range(0, 100) - 50));
    @(negedge clk);
    bus.ALUControl = OP_CONV;
    bus.valid_in = 1'b1;
    #1 check("err_before", bus.err, 1'b0);
    @(negedge clk);
    bus.ALUControl = OP_READ;
    bus.valid_in = 1'b0;
    exp_err = 1'b1;
    #1;
    check("err_set", bus.err, 1'b1);
    check("err_busy", bus.busy, 1'b0);
    check("err_read", bus.Result, exp_conv);
    repeat (3) @(negedge clk);
    #1 check("err_idle_busy", bus.busy, 1'b0);

    // ten more loads wrap the window; a load during MAC must be ignored
    for (int i = 0; i < 10; i++) do_load(8'($urandom_range(0, 100) - 50), 8'($urandom_range(0, 100) - 50));
    full_conv(1);

    // random full windows
    for (int r = 0; r < 3; r++) begin
      rand_loads(NSLOT);
      full_conv(0);
    end

    // reset at MAC cycle 4 aborts the convolution
    rand_loads(NSLOT);
    run_conv(4, 0, dc, nb);
    ndone = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      bus.ALUControl = OP_READ;
      bus.valid_in = 1'b0;
      #1;
      if (bus.done) ndone++;
    end
    exp_conv = 32'h0;
    exp_err = 1'b0;
    win.delete();
    check("abort_no_done", 32'(ndone), 32'd0);
    check("abort_busy", bus.busy, 1'b0);
    check("abort_read", bus.Result, 32'h0);
    check("abort_err", bus.err, 1'b0);

    // resumes after reset; 110 held while busy is ignored and sets no error
    rand_loads(NSLOT);
    full_conv(2);
    rand_loads(NSLOT);
    full_conv(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv_alu.md
CONV_ALU -- requirements
Module: conv_alu

Interface
REQ-001 Parameter DATA_W, default 32: width of A, B, Result.
REQ-002 Parameter ELEM_W, default 8: signed activation/weight element width.
REQ-003 Parameter K, default 3: kernel edge; window holds K*K elements, legal K = 2..4.
REQ-004 Parameter ACC_W, default 20: signed MAC accumulator width; ACC_W SHALL be >= 2*ELEM_W+4 and <= DATA_W.
REQ-005 clk  input  1  sole clock; all state rises on posedge clk.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 A  input  DATA_W  operand A.
REQ-008 B  input  DATA_W  operand B; for load, B[2*ELEM_W-1:ELEM_W] is the activation and B[ELEM_W-1:0] is the weight.
REQ-009 ALUControl  input  3  operation select.
REQ-010 valid_in  input  1  qualifies ALUControl for sequential ops (100, 110).
REQ-011 Result  output  DATA_W  operation result.
REQ-012 Carry, OverFlow, Zero, Negative  output  1 each  status flags.
REQ-013 busy  output  1  MAC engine active.
REQ-014 done  output  1  one-cycle pulse when a convolution result is committed.
REQ-015 err  output  1  sticky: convolution issued on a non-full window; cleared only by reset.

Function
REQ-016 000 add, 001 sub (A + ~B + 1), 010 A&B, 011 A|B: combinational, same-cycle Result.
REQ-017 Carry = carry-out of add/sub, 0 for all other ops.
REQ-018 OverFlow = two's-complement overflow of add/sub, 0 for all other ops.
REQ-019 Zero = (Result == 0); Negative = Result[DATA_W-1]; both apply to every op.
REQ-020 100 load: Result = B combinationally.
REQ-021 100 load: on posedge with valid_in=1 and busy=0, the activation and weight are written to buffer slot wr_ptr, wr_ptr increments, and fill increments up to K*K.
REQ-022 Load with fill == K*K: wr_ptr wraps to 0, the oldest slot is overwritten, fill stays K*K.
REQ-023 Load while busy=1: ignored; buffer, wr_ptr and fill unchanged.
REQ-024 101 ReLU: Result = A with every signed ELEM_W lane clamped to 0 when negative; combinational; lanes above DATA_W/ELEM_W*ELEM_W pass through.
REQ-025 110 convolution start: on posedge with valid_in=1, busy=0 and fill == K*K, FSM moves IDLE->MAC and clears acc.
REQ-026 110 with fill < K*K: no state change; err set next cycle.
REQ-027 MAC state: one signed ELEM_W x ELEM_W product of slot idx is added to acc per cycle, idx running 0..K*K-1, so the state lasts exactly K*K cycles, then goes to DONE.
REQ-028 Accumulation: full ACC_W precision with no intermediate saturation.
REQ-029 DONE state: lasts one cycle; conv_res <= acc sign-extended to DATA_W; done=1; fill and wr_ptr clear to 0; FSM returns to IDLE.
REQ-030 busy = 1 in MAC and DONE, 0 in IDLE.
REQ-031 Latency: issue cycle N; done asserted in cycle N+K*K+1; a new 110 is accepted at N+K*K+2 at the earliest.
REQ-032 111 read: Result = conv_res (last committed value) combinationally, legal at any time, also while busy.
REQ-033 Result for 110 = 0.
REQ-034 110 while busy: ignored; err is not set.
REQ-035 Unlisted or invalid conditions leave all state unchanged.

Reset
REQ-036 rst low immediately forces: FSM=IDLE, acc=0, conv_res=0, buffer=0, wr_ptr=0, fill=0, idx=0, busy=0, done=0, err=0.
REQ-037 Reset asserted mid-MAC aborts the operation: no done pulse, conv_res stays 0.
REQ-038 Operation resumes on the first posedge after rst rises.

Verification
REQ-039 Reset, then 9 loads with B=0x0000_0201 (act 2, weight 1), then 110 -> busy for 10 cycles, done at N+10, then 111 Result=18, Zero=0.
REQ-040 Load act=-3 (0xFD), weight=4 in all 9 slots, then conv -> Result via 111 = 0xFFFF_FF94 (-108), Negative=1.
REQ-041 5 loads then 110 -> err=1, busy stays 0, conv_res unchanged; 10 loads (wrap) then conv -> slot 0 holds the 10th load.
REQ-042 Add 0x7FFF_FFFF + 1 -> Result 0x8000_0000, OverFlow=1, Carry=0; sub 5-5 -> Zero=1, Carry=1.
REQ-043 ReLU A=0x80_7F_FF_01 -> Result 0x00_7F_00_01; load during MAC ignored; rst pulse at MAC cycle 4 -> busy=0, done never pulses.
